imem_loader: RTL and testbench

Upstream instruction-supply stage for the 8-bit MIPS core. The core takes its 8-bit `Instruction` from outside and exports `PC`; this block supplies that `Instruction`. It works in two modes:
- **LOAD:** the user enters a program byte-by-byte from board switches and a debounced pushbutton. The core is held in reset.
- **RUN:** the block serves `Instruction` from its internal program RAM, indexed by the core's `PC`.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_btn_debounce.sv | 57 +++++
 rtl/imem_loader.sv | 103 ++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_loader_pkg: mode encoding and fill default for imem_loader   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package imem_loader_pkg;

  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_RUN  = 1'b1
  } mode_e;

  localparam logic [7:0] FILL_INSTR_DEFAULT = 8'h00;

endpackage
`default_nettype wire

// File: rtl/imem_loader_btn_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_debounce: 2-flop sync, stability counter, registered press    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module btn_debounce
  import imem_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_loader: switch/button program loader and instruction server  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W          = 4,
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [7:0] FILL_INSTR      = FILL_INSTR_DEFAULT
) (
  input  logic            Clk_O,
  input  logic            Reset,
  input  logic [7:0]      Switch,
  input  logic            Load_Btn,
  input  logic            Run_Btn,
  input  logic [7:0]      PC,
  output logic [7:0]      Instruction,
  output logic            Cpu_Reset,
  output logic            Mode,
  output logic [ADDR_W:0] Load_Count,
  output logic            Full
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CMP_W = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;
  localparam logic [ADDR_W:0] COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  mode_e            mode_q, mode_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic [7:0]       instr_q, instr_d;
  logic [7:0]       mem_q [DEPTH];
  logic             load_press, run_press, wr_en, full;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk_i  (Clk_O),
    .rst_i  (Reset),
    .btn_i  (Load_Btn),
    .press_o(load_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk_i  (Clk_O),
    .rst_i  (Reset),
    .btn_i  (Run_Btn),
    .press_o(run_press)
  );

  assign full = (count_q == COUNT_FULL);

  // In LOAD the run decision sees the post-write count, so load+run from 0 enters RUN.
  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    wr_en   = 1'b0;
    instr_d = 8'h00;
    if (mode_q == MODE_LOAD) begin
      wr_en   = load_press && !full;
      count_d = count_q + {{ADDR_W{1'b0}}, wr_en};
      if (run_press && (count_d != '0)) begin
        mode_d = MODE_RUN;
      end
    end else if (run_press) begin
      mode_d  = MODE_LOAD;
      count_d = '0;
    end
    if (mode_d == MODE_RUN) begin
      if (CMP_W'(PC) < CMP_W'(count_q)) begin
        instr_d = mem_q[PC[ADDR_W-1:0]];
      end else begin
        instr_d = FILL_INSTR;
      end
    end
  end

  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      mode_q  <= MODE_LOAD;
      count_q <= '0;
      instr_q <= 8'h00;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      instr_q <= instr_d;
    end
  end

  // Program RAM is deliberately left uncleared by reset.
  always_ff @(posedge Clk_O) begin
    if (wr_en) begin
      mem_q[count_q[ADDR_W-1:0]] <= Switch;
    end
  end

  assign Instruction = instr_q;
  assign Mode        = mode_q;
  assign Cpu_Reset   = (mode_q == MODE_LOAD);
  assign Load_Count  = count_q;
  assign Full        = full;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_imem_loader: randomized self-checking bench with a mode model  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int DEB    = 4;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw  = 8'h00;
  logic [7:0] pc  = 8'h00;
  logic       ld  = 1'b0;
  logic       rn  = 1'b0;
  logic [7:0] instr;
  logic       cpu_rst, mode, full;
  logic [4:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode flag, byte count and program contents.
  bit         m_run;
  int         m_count;
  logic [7:0] m_mem [DEPTH];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DEBOUNCE_CYCLES(DEB), .FILL_INSTR(8'h00)) dut (
    .Clk_O(clk), .Reset(rst), .Switch(sw), .Load_Btn(ld), .Run_Btn(rn), .PC(pc),
    .Instruction(instr), .Cpu_Reset(cpu_rst), .Mode(mode), .Load_Count(cnt), .Full(full)
  );

  task automatic model_reset();
    m_run = 1'b0;
    m_count = 0;
  endtask

  task automatic model_press(bit l, bit r, logic [7:0] b);
    if (!m_run) begin
      if (l && m_count < DEPTH) begin
        m_mem[m_count] = b;
        m_count++;
      end
      if (r && m_count > 0) m_run = 1'b1;
    end else if (r) begin
      m_run = 1'b0;
      m_count = 0;
    end
  endtask

  function automatic logic [7:0] model_instr(int p);
    if (!m_run) return 8'h00;
    if (p < m_count) return m_mem[p];
    return 8'h00;
  endfunction

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(bit l, bit r, logic [7:0] b);
    @(negedge clk);
    sw = b; ld = l; rn = r;
    cycles(8);
    ld = 1'b0; rn = 1'b0;
    cycles(8);
    model_press(l, r, b);
  endtask

  task automatic read_pc(logic [7:0] p);
    @(negedge clk);
    pc = p;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycles(3);
    n_tests++; if (mode !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %0h want 0", mode); end
    n_tests++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %0h want 1", cpu_rst); end
    n_tests++; if (instr !== 8'h00) begin n_fail++; $display("FAIL reset_instr: got %0h want 00", instr); end
    n_tests++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0h want 0", full); end
    rst = 1'b0;
    model_reset();
    press(1'b0, 1'b1, 8'h00);
    n_tests++; if (mode !== 1'b0) begin n_fail++; $display("FAIL run_at_zero_mode: got %0h want 0", mode); end
  endtask

  task automatic test_load_run();
    logic [7:0] pcs [5];
    logic [7:0] exp [5];
    logic [7:0] p;
    pcs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20};
    exp = '{8'h41, 8'h86, 8'hC3, 8'h00, 8'h00};
    press(1'b1, 1'b0, 8'h41);
    press(1'b1, 1'b0, 8'h86);
    press(1'b1, 1'b0, 8'hC3);
    n_tests++; if (cnt !== 5'd3) begin n_fail++; $display("FAIL load3_count: got %0d want 3", cnt); end
    @(negedge clk);
    rn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_tests++; if (mode !== 1'b0) begin n_fail++; $display("FAIL run_early_mode: got %0h want 0", mode); end
    @(posedge clk);
    #1;
    n_tests++; if (mode !== 1'b1) begin n_fail++; $display("FAIL run_mode: got %0h want 1", mode); end
    n_tests++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL run_cpu_rst: got %0h want 0", cpu_rst); end
    @(negedge clk);
    rn = 1'b0;
    cycles(8);
    model_press(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      read_pc(pcs[i]);
      n_tests++;
      if (instr !== exp[i] || instr !== model_instr(int'(pcs[i]))) begin
        n_fail++; $display("FAIL run_instr_pc%0h: got %0h want %0h", pcs[i], instr, exp[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      p = 8'($urandom_range(0, 255));
      read_pc(p);
      n_tests++;
      if (instr !== model_instr(int'(p))) begin
        n_fail++; $display("FAIL run_rand_pc%0h: got %0h want %0h", p, instr, model_instr(int'(p)));
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] b;
    press(1'b0, 1'b1, 8'h00);
    n_tests++; if (mode !== 1'b0 || cnt !== 5'd0) begin n_fail++; $display("FAIL back_to_load: got mode %0h cnt %0d want 0 0", mode, cnt); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ld = ((i % 6) < 3);
    end
    @(negedge clk);
    ld = 1'b0;
    cycles(8);
    n_tests++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL bounce_count: got %0d want 0", cnt); end
    b = 8'($urandom);
    @(negedge clk);
    sw = b; ld = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_tests++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL hold_early_count: got %0d want 0", cnt); end
    @(posedge clk);
    #1;
    n_tests++; if (cnt !== 5'd1) begin n_fail++; $display("FAIL hold_latency_count: got %0d want 1", cnt); end
    cycles(3);
    ld = 1'b0;
    cycles(8);
    model_press(1'b1, 1'b0, b);
    n_tests++; if (cnt !== 5'(m_count)) begin n_fail++; $display("FAIL hold_single_write: got %0d want %0d", cnt, m_count); end
    press(1'b0, 1'b1, 8'h00);
    read_pc(8'h00);
    n_tests++; if (instr !== b) begin n_fail++; $display("FAIL hold_byte: got %0h want %0h", instr, b); end
  endtask

  task automatic test_full();
    logic [7:0] b, last;
    press(1'b0, 1'b1, 8'h00);
    last = 8'h00;
    for (int i = 1; i <= 17; i++) begin
      b = 8'($urandom);
      if (i == 16) last = b;
      press(1'b1, 1'b0, b);
      if (i == 15) begin
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_at15: got %0h want 0", full); end
      end
    end
    n_tests++; if (cnt !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", cnt); end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %0h want 1", full); end
    press(1'b0, 1'b1, 8'h00);
    read_pc(8'h0F);
    n_tests++; if (instr !== last) begin n_fail++; $display("FAIL full_mem15: got %0h want %0h", instr, last); end
    for (int p = 0; p <= 16; p++) begin
      read_pc(8'(p));
      n_tests++;
      if (instr !== model_instr(p)) begin
        n_fail++; $display("FAIL full_pc%0d: got %0h want %0h", p, instr, model_instr(p));
      end
    end
  endtask

  task automatic test_simultaneous();
    press(1'b0, 1'b1, 8'h00);
    press(1'b1, 1'b1, 8'h55);
    n_tests++; if (cnt !== 5'd1) begin n_fail++; $display("FAIL simul_count: got %0d want 1", cnt); end
    n_tests++; if (mode !== 1'b1) begin n_fail++; $display("FAIL simul_mode: got %0h want 1", mode); end
    read_pc(8'h00);
    n_tests++; if (instr !== 8'h55) begin n_fail++; $display("FAIL simul_instr: got %0h want 55", instr); end
  endtask

  task automatic test_reload_reset();
    press(1'b0, 1'b1, 8'h00);
    n_tests++; if (mode !== 1'b0) begin n_fail++; $display("FAIL reload_mode: got %0h want 0", mode); end
    n_tests++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL reload_count: got %0d want 0", cnt); end
    n_tests++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reload_cpu_rst: got %0h want 1", cpu_rst); end
    n_tests++; if (instr !== 8'h00) begin n_fail++; $display("FAIL reload_instr: got %0h want 00", instr); end
    press(1'b1, 1'b0, 8'h99);
    press(1'b0, 1'b1, 8'h00);
    read_pc(8'h00);
    n_tests++; if (instr !== 8'h99) begin n_fail++; $display("FAIL reload_pc0: got %0h want 99", instr); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (mode !== 1'b0) begin n_fail++; $display("FAIL async_mode: got %0h want 0", mode); end
    n_tests++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL async_cpu_rst: got %0h want 1", cpu_rst); end
    n_tests++; if (instr !== 8'h00) begin n_fail++; $display("FAIL async_instr: got %0h want 00", instr); end
    n_tests++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL async_count: got %0d want 0", cnt); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit l, r;
    logic [7:0] b, p;
    for (int i = 0; i < 30; i++) begin
      l = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) == 0);
      b = 8'($urandom);
      press(l, r, b);
      n_tests++;
      if (cnt !== 5'(m_count) || mode !== m_run) begin
        n_fail++; $display("FAIL rand_state_%0d: got cnt %0d mode %0h want cnt %0d mode %0h", i, cnt, mode, m_count, m_run);
      end
      p = 8'($urandom_range(0, 20));
      read_pc(p);
      n_tests++;
      if (instr !== model_instr(int'(p))) begin
        n_fail++; $display("FAIL rand_instr_%0d: pc %0h got %0h want %0h", i, p, instr, model_instr(int'(p)));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_run();
    test_bounce();
    test_full();
    test_simultaneous();
    test_reload_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
